// File: rtl/fft_bfu_sched_if.sv
// ---------------------------------------------------------------------------
// fft_bfu_sched_if
// Bus bundle between the FFT butterfly scheduler and its environment.
//   start                 : request a transform (controller -> scheduler)
//   stall                 : issue hold, present only with FFT_SCHED_STALL_EN
//   busy, done, stage     : scheduler status
//   rd_en, rd_addr_a/b    : sample RAM read strobe and butterfly addresses
//   tw_addr               : twiddle ROM index aligned with rd_en
//   wr_en, wr_addr_a/b    : write-back strobe and addresses aligned with BFU
// Modports: master = controller side, slave = scheduler side.
// ---------------------------------------------------------------------------
interface fft_bfu_sched_if #(
  parameter int N_LOG2 = 4
);
  localparam int SW = ($clog2(N_LOG2) < 1) ? 1 : $clog2(N_LOG2);

  logic              start;
  logic              busy;
  logic              done;
  logic [SW-1:0]     stage;
  logic              rd_en;
  logic [N_LOG2-1:0] rd_addr_a;
  logic [N_LOG2-1:0] rd_addr_b;
  logic [N_LOG2-2:0] tw_addr;
  logic              wr_en;
  logic [N_LOG2-1:0] wr_addr_a;
  logic [N_LOG2-1:0] wr_addr_b;
`ifdef FFT_SCHED_STALL_EN
  logic              stall;

  modport master (
    output start, stall,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b
  );
  modport slave (
    input  start, stall,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b
  );
`else
  modport master (
    output start,
    input  busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b
  );
  modport slave (
    input  start,
    output busy, done, stage, rd_en, rd_addr_a, rd_addr_b, tw_addr,
           wr_en, wr_addr_a, wr_addr_b
  );
`endif
endinterface

// File: rtl/fft_bfu_sched.sv
// ---------------------------------------------------------------------------
// fft_bfu_sched
// Sequencer for a single radix-2 butterfly unit running an in-place N-point
// DIT FFT on a dual-port sample RAM (data already bit-reverse loaded).
// Per stage it issues N/2 butterfly reads (A/B address + twiddle index),
// delays the addresses by RD_LAT+BFU_LAT cycles to form the write-back
// strobes, and waits until every write of the stage has landed before the
// next stage starts reading.
//
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset; abandons any transform in flight
//   bus   : fft_bfu_sched_if.slave (start, busy, done, stage, rd_*, tw_addr,
//           wr_*; plus stall when FFT_SCHED_STALL_EN is defined)
//
// Build option: FFT_SCHED_STALL_EN adds bus.stall, which freezes issue in RUN
// while the write pipe keeps shifting (the BFU itself cannot be held).
//
// All outputs are decodes of registered state; address outputs are forced to
// zero whenever their strobe is low so the idle bus is all-zero.
// ---------------------------------------------------------------------------
module fft_bfu_sched #(
  parameter int N_LOG2  = 4,
  parameter int RD_LAT  = 1,
  parameter int BFU_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  fft_bfu_sched_if.slave   bus
);
  localparam int WR_DLY = RD_LAT + BFU_LAT;
  localparam int SW     = ($clog2(N_LOG2) < 1) ? 1 : $clog2(N_LOG2);
  localparam int CW     = $clog2(WR_DLY + 1);
  localparam int TW_W   = N_LOG2 - 1;
  localparam logic [N_LOG2-1:0] K_LAST = N_LOG2'((1 << (N_LOG2 - 1)) - 1);
  localparam logic [SW-1:0]     LAST_S = SW'(N_LOG2 - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r, state_nx_s;
  logic [SW-1:0]     s_r, s_nx_s;
  logic [N_LOG2-1:0] k_r, k_nx_s;
  logic [CW-1:0]     inflight_r;
  logic              issue_s;
  logic              stall_s;
  logic              wr_en_s;
  logic [N_LOG2-1:0] mask_s, pos_s, addr_a_s, addr_b_s;
  logic [N_LOG2-1:0] rd_a_s, rd_b_s;
  logic [TW_W-1:0]   tw_s, rd_tw_s;

  logic              pipe_v_r [WR_DLY];
  logic [N_LOG2-1:0] pipe_a_r [WR_DLY];
  logic [N_LOG2-1:0] pipe_b_r [WR_DLY];

`ifdef FFT_SCHED_STALL_EN
  assign stall_s = bus.stall;
`else
  assign stall_s = 1'b0;
`endif

  assign wr_en_s = pipe_v_r[WR_DLY-1];

  // Butterfly addressing: a inserts a zero at bit s of k, b sets that bit.
  always_comb begin
    mask_s   = (N_LOG2'(1) << s_r) - N_LOG2'(1);
    pos_s    = k_r & mask_s;
    addr_a_s = ((k_r & ~mask_s) << 1'b1) | pos_s;
    addr_b_s = addr_a_s | (N_LOG2'(1) << s_r);
    tw_s     = TW_W'(pos_s << (LAST_S - s_r));
    if (issue_s) begin
      rd_a_s  = addr_a_s;
      rd_b_s  = addr_b_s;
      rd_tw_s = tw_s;
    end else begin
      rd_a_s  = {N_LOG2{1'b0}};
      rd_b_s  = {N_LOG2{1'b0}};
      rd_tw_s = {TW_W{1'b0}};
    end
  end

  // Next-state, stage/k sequencing and read issue.
  always_comb begin
    state_nx_s = state_r;
    s_nx_s     = s_r;
    k_nx_s     = k_r;
    issue_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.start) begin
          state_nx_s = ST_RUN;
          s_nx_s     = {SW{1'b0}};
          k_nx_s     = {N_LOG2{1'b0}};
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stall_s) begin
          state_nx_s = ST_RUN;
        end else begin
          issue_s = 1'b1;
          if (k_r == K_LAST) begin
            k_nx_s     = {N_LOG2{1'b0}};
            state_nx_s = ST_DRAIN;
          end else begin
            k_nx_s = k_r + N_LOG2'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Reads of the next stage must not start until the last write lands.
        if (inflight_r == {CW{1'b0}}) begin
          if (s_r == LAST_S) begin
            state_nx_s = ST_DONE;
          end else begin
            s_nx_s     = s_r + SW'(1);
            state_nx_s = ST_RUN;
          end
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      ST_DONE: begin
        // A start held across DONE chains straight into the next transform.
        if (bus.start) begin
          state_nx_s = ST_RUN;
          s_nx_s     = {SW{1'b0}};
          k_nx_s     = {N_LOG2{1'b0}};
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // FSM, stage and butterfly index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      s_r     <= {SW{1'b0}};
      k_r     <= {N_LOG2{1'b0}};
    end else begin
      state_r <= state_nx_s;
      s_r     <= s_nx_s;
      k_r     <= k_nx_s;
    end
  end

  // In-flight butterfly counter: up on issue, down on write-back.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_r <= {CW{1'b0}};
    end else begin
      case ({issue_s, wr_en_s})
        2'b10:   inflight_r <= inflight_r + CW'(1);
        2'b01:   inflight_r <= inflight_r - CW'(1);
        default: inflight_r <= inflight_r;
      endcase
    end
  end

  // Write-back delay line; free-running because the BFU has no enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WR_DLY; i++) begin
        pipe_v_r[i] <= 1'b0;
        pipe_a_r[i] <= {N_LOG2{1'b0}};
        pipe_b_r[i] <= {N_LOG2{1'b0}};
      end
    end else begin
      pipe_v_r[0] <= issue_s;
      pipe_a_r[0] <= rd_a_s;
      pipe_b_r[0] <= rd_b_s;
      for (int i = 1; i < WR_DLY; i++) begin
        pipe_v_r[i] <= pipe_v_r[i-1];
        pipe_a_r[i] <= pipe_a_r[i-1];
        pipe_b_r[i] <= pipe_b_r[i-1];
      end
    end
  end

  assign bus.busy      = (state_r == ST_RUN) || (state_r == ST_DRAIN);
  assign bus.done      = (state_r == ST_DONE);
  assign bus.stage     = s_r;
  assign bus.rd_en     = issue_s;
  assign bus.rd_addr_a = rd_a_s;
  assign bus.rd_addr_b = rd_b_s;
  assign bus.tw_addr   = rd_tw_s;
  assign bus.wr_en     = wr_en_s;
  assign bus.wr_addr_a = pipe_a_r[WR_DLY-1];
  assign bus.wr_addr_b = pipe_b_r[WR_DLY-1];

  fft_bfu_sched_chk #(
    .N_LOG2 (N_LOG2),
    .CW     (CW)
  ) u_chk (
    .clk      (clk),
    .rst      (rst),
    .k        (k_r),
    .inflight (inflight_r),
    .issue    (issue_s),
    .wr_en    (wr_en_s)
  );
endmodule

// ---------------------------------------------------------------------------
// fft_bfu_sched_chk
// Property checker for the scheduler: butterfly index never passes N/2-1 and
// the in-flight counter never underflows.
// ---------------------------------------------------------------------------
module fft_bfu_sched_chk #(
  parameter int N_LOG2 = 4,
  parameter int CW     = 3
) (
  input logic              clk,
  input logic              rst,
  input logic [N_LOG2-1:0] k,
  input logic [CW-1:0]     inflight,
  input logic              issue,
  input logic              wr_en
);
  localparam logic [N_LOG2-1:0] K_LAST = N_LOG2'((1 << (N_LOG2 - 1)) - 1);

  a_k_range: assert property (@(posedge clk) disable iff (rst) k <= K_LAST);
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    !(wr_en && !issue && (inflight == {CW{1'b0}})));
endmodule

// File: tb/tb_fft_bfu_sched.sv
// ---------------------------------------------------------------------------
// tb_fft_bfu_sched
// Directed bench for fft_bfu_sched at N=16, RD_LAT=1, BFU_LAT=4.
// Cycle c is the clock period following the c-th rising edge after the
// cycle in which start is first presented (cycle 0); outputs are sampled
// 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_fft_bfu_sched;
  localparam int N_LOG2 = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   rd_total, wr_total;
  logic [3:0] seen;

  always #5 clk = ~clk;

  fft_bfu_sched_if #(.N_LOG2(N_LOG2)) bus ();

  fft_bfu_sched #(
    .N_LOG2  (N_LOG2),
    .RD_LAT  (1),
    .BFU_LAT (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Single comparison point: counts every check, reports any miscompare.
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [31:0] all_outs();
    return {7'd0, bus.busy, bus.done, bus.stage, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b,
            bus.tw_addr, bus.wr_en, bus.wr_addr_a, bus.wr_addr_b};
  endfunction

  function automatic logic [31:0] rd_vec();
    return {20'd0, bus.rd_en, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr};
  endfunction

  function automatic logic [31:0] wr_vec();
    return {23'd0, bus.wr_en, bus.wr_addr_a, bus.wr_addr_b};
  endfunction

  initial begin
    bus.start = 1'b0;
`ifdef FFT_SCHED_STALL_EN
    bus.stall = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check_val("reset_outs", all_outs(), 32'd0);

    // ---- Run 1: single transform, addresses, hazard, ignored start pulses
    cyc = 0;
    bus.start = 1'b1;
    rd_total = 0;
    wr_total = 0;
    seen = 4'd0;
    for (int c = 1; c <= 60; c++) begin
      step();
      bus.start = (cyc == 10) || (cyc == 30);
      check_val("r1_busy", {31'd0, bus.busy}, {31'd0, (cyc >= 1 && cyc <= 56)});
      check_val("r1_done", {31'd0, bus.done}, {31'd0, (cyc == 57)});
      if (bus.rd_en) begin
        rd_total++;
        check_val("r1_hazard", {31'd0, (wr_total >= 8 * int'(bus.stage))}, 32'd1);
        if (!seen[bus.stage]) begin
          seen[bus.stage] = 1'b1;
          check_val("r1_stage_start", cyc, 1 + 14 * int'(bus.stage));
        end
      end
      if (bus.wr_en) begin
        wr_total++;
        if (wr_total == 8) check_val("r1_s0_last_wr", cyc, 32'd13);
      end
      case (cyc)
        1:  check_val("r1_rd_s0k0", rd_vec(), {20'd0, 1'b1, 4'd0, 4'd1, 3'd0});
        6:  check_val("r1_wr_s0k0", wr_vec(), {23'd0, 1'b1, 4'd0, 4'd1});
        14: check_val("r1_wr_gap", {31'd0, bus.wr_en}, 32'd0);
        18: check_val("r1_rd_s1k3", rd_vec(), {20'd0, 1'b1, 4'd5, 4'd7, 3'd4});
        23: check_val("r1_wr_s1k3", wr_vec(), {23'd0, 1'b1, 4'd5, 4'd7});
        48: check_val("r1_rd_s3k5", rd_vec(), {20'd0, 1'b1, 4'd5, 4'd13, 3'd5});
        53: check_val("r1_wr_s3k5", wr_vec(), {23'd0, 1'b1, 4'd5, 4'd13});
        58: check_val("r1_stage_hold", {30'd0, bus.stage}, 32'd3);
        default: ;
      endcase
    end
    check_val("r1_rd_total", rd_total, 32'd32);
    check_val("r1_wr_total", wr_total, 32'd32);
    check_val("r1_seen_all", {28'd0, seen}, 32'd15);

    // ---- Run 2: start held high chains a second transform after DONE
    cyc = 0;
    bus.start = 1'b1;
    for (int c = 1; c <= 116; c++) begin
      step();
      if (cyc == 58) bus.start = 1'b0;
      check_val("r2_busy", {31'd0, bus.busy},
                {31'd0, ((cyc >= 1 && cyc <= 56) || (cyc >= 58 && cyc <= 113))});
      check_val("r2_done", {31'd0, bus.done}, {31'd0, (cyc == 57 || cyc == 114)});
      if (cyc == 58) begin
        check_val("r2_rerun_rd", rd_vec(), {20'd0, 1'b1, 4'd0, 4'd1, 3'd0});
        check_val("r2_rerun_stage", {30'd0, bus.stage}, 32'd0);
      end
    end

    // ---- Run 3: reset in stage 1 abandons the transform, restart at 25
    cyc = 0;
    bus.start = 1'b1;
    for (int c = 1; c <= 85; c++) begin
      step();
      rst = (cyc == 20);
      bus.start = (cyc == 25);
      check_val("r3_done", {31'd0, bus.done}, {31'd0, (cyc == 82)});
      if (cyc == 20) check_val("r3_pre_rst_stage", {30'd0, bus.stage}, 32'd1);
      if (cyc == 21) check_val("r3_rst_outs", all_outs(), 32'd0);
      if (cyc >= 21 && cyc <= 30) check_val("r3_no_wr", {31'd0, bus.wr_en}, 32'd0);
      if (cyc >= 21) check_val("r3_busy", {31'd0, bus.busy}, {31'd0, (cyc >= 26 && cyc <= 81)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
